subtrator_serial: RTL and testbench
===================================

Name: subtrator_serial

Overview:
- Multi-cycle unsigned subtractor, the inverse operation to the cascade adder.
- Computes A − B over W bits per cycle, with the borrow registered between chunks.
- Result is N+1 bits wide; the top bit is the borrow-out. This gives full-range subtraction without wrap ambiguity.
- Used where a full N-bit ripple path per cycle is too slow, e.g. multi-cycle ALU ops and compare-by-subtract in the pipeline's execute stage.

Parameters:
- N, 64, operand width in bits.
- W, 8, bits processed per cycle. N must be an integer multiple of W; otherwise elaboration fails with $error.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  N  minuend; sampled on the accepted start edge only.
- B  input  N  subtrahend; sampled on the accepted start edge only.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse; RES is valid from this cycle on.
- RES  output  N+1  RES[N-1:0] = (A − B) mod 2^N; RES[N] = borrow-out, i.e. 1 iff A < B unsigned.

Behaviour:
- Reset, synchronous and active-high. At the clk edge with reset=1:
  - state=IDLE, busy=0, done=0, RES=0.
  - Internal chunk index, borrow and operand registers are cleared.
  - Reset overrides everything, including mid-operation; a partial result is never exposed.
- States:
  - IDLE: waiting for start.
  - RUN: processing chunks.
- IDLE → RUN, on an edge with start=1:
  - Latch A and B.
  - Set borrow=0, idx=0, busy=1.
- RUN, each edge, for chunk k = idx:
  - {b_out, d} = A[kW+W-1:kW] − B[kW+W-1:kW] − borrow, computed over W+1 bits.
  - Write d into the result register at chunk k; borrow ← b_out; idx ← idx+1.
  - Chunk 0 is the least-significant chunk.
- RUN → IDLE, on the edge processing chunk N/W − 1:
  - RES[N] ← final b_out; busy ← 0; done ← 1 for exactly one cycle.
- Latency:
  - Start accepted at edge t. Chunks are processed at edges t+1 … t+N/W.
  - done and valid RES are visible after edge t+N/W: 8 edges for the defaults.
- RES:
  - Updated only at the completion edge, from a shadow register.
  - Between completions it holds the last result. It never shows a half-computed value.
- start while busy=1: ignored, with no effect on operands or timing.
- start in the done cycle: state is already IDLE, so it is accepted. Back-to-back throughput is one result per N/W cycles plus one idle cycle between accepted starts.
- A/B may change freely after the accepting edge.
- N/W = 1 is legal: done follows start after one edge.

Optional Feature:
- Macro: SUBTRATOR_OVERFLOW_EN.
- When defined: an extra output port ovf (1 bit) is present. It is updated together with RES and done, reset to 0, and held like RES.
  - ovf = two's-complement signed overflow of A − B over N bits.
  - Formula: (A[N-1] != B[N-1]) && (RES[N-1] != A[N-1]), using the latched operands.
- When undefined: port ovf and its logic are absent. All other behaviour is identical.

Test Plan (defaults N=64, W=8):
- Simple: start with A=10, B=3 → done exactly 8 cycles after the start edge; RES[63:0]=7, RES[64]=0; busy high for those 8 cycles.
- Full borrow chain: A=0, B=1 → RES[63:0]=0xFFFF_FFFF_FFFF_FFFF, RES[64]=1.
- Inter-chunk borrow: A=0x100, B=0x1 → RES=0xFF, RES[64]=0.
- Equal operands: A=B=0xFFFF_FFFF_FFFF_FFFF → RES=0, RES[64]=0.
- Ignore/reset: start with A=5, B=2, then at cycle 3:
  - Pulse start with A=9, B=9 → still RES=3 at cycle 8.
  - Repeat, asserting reset at cycle 4 → busy=0, done never pulses, RES=0.
  - A start accepted in the cycle after reset completes normally.
- Overflow (macro defined):
  - A=0x8000_0000_0000_0000, B=1 → RES[63:0]=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
  - A=5, B=3 → ovf=0.

Source files
------------

// File: rtl/subtrator_serial.sv
// Multi-cycle unsigned subtractor: A - B, W bits per clock, borrow carried between chunks.
// Optional macro SUBTRATOR_OVERFLOW_EN adds a signed-overflow output 'ovf'.
module subtrator_serial #(
    parameter int N = 64,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N:0]   RES
`ifdef SUBTRATOR_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);

    localparam int CHUNKS = N / W;
    localparam int IDXW   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if ((W < 1) || ((N % W) != 0)) begin : g_bad_param
        $error("subtrator_serial: N (%0d) must be an integer multiple of W (%0d)", N, W);
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            borrow_q, borrow_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    shadow_q, shadow_d;
    logic [N:0]      res_q, res_d;
    logic            done_q, done_d;
    logic [W:0]      diff;
    logic            lastChunk;
`ifdef SUBTRATOR_OVERFLOW_EN
    logic            ovf_q, ovf_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
`ifdef SUBTRATOR_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            res_q    <= res_d;
            done_q   <= done_d;
`ifdef SUBTRATOR_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Chunks accumulate in shadow_q; RES only changes at the completion edge.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        borrow_d  = borrow_q;
        a_d       = a_q;
        b_d       = b_q;
        shadow_d  = shadow_q;
        res_d     = res_q;
        done_d    = 1'b0;
`ifdef SUBTRATOR_OVERFLOW_EN
        ovf_d     = ovf_q;
`endif
        diff      = {1'b0, a_q[int'(idx_q) * W +: W]}
                  - {1'b0, b_q[int'(idx_q) * W +: W]}
                  - {{W{1'b0}}, borrow_q};
        lastChunk = (idx_q == IDXW'(CHUNKS - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_d      = A;
                    b_d      = B;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                end
            end
            RUN: begin
                shadow_d[int'(idx_q) * W +: W] = diff[W-1:0];
                borrow_d = diff[W];
                idx_d    = idx_q + 1'b1;
                if (lastChunk) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    res_d   = {diff[W], shadow_d};
                    done_d  = 1'b1;
`ifdef SUBTRATOR_OVERFLOW_EN
                    ovf_d   = (a_q[N-1] != b_q[N-1]) && (shadow_d[N-1] != a_q[N-1]);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign RES  = res_q;
`ifdef SUBTRATOR_OVERFLOW_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial (N=64, W=8): directed vector table plus
// hand-written ignore/reset sequences. Overflow checks compile in with SUBTRATOR_OVERFLOW_EN.
module tb_subtrator_serial;

    localparam int N   = 64;
    localparam int W   = 8;
    localparam int LAT = N / W;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N:0]   RES;
`ifdef SUBTRATOR_OVERFLOW_EN
    logic         ovf;
`endif

    int nChecks = 0;
    int nFail   = 0;

    subtrator_serial #(.N(N), .W(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .RES  (RES)
`ifdef SUBTRATOR_OVERFLOW_EN
        ,
        .ovf  (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N:0]   expRes;
        logic         expOvf;
        string        name;
    } vector_t;

    task automatic checkOutput(input string name, input logic [N:0] act, input logic [N:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is positioned just after a negedge; returns just after a negedge.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                                 output int lat, output int busyCnt);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = ~a;
        B     = ~b;
        lat     = 0;
        busyCnt = 0;
        while (!done && lat < 20) begin
            if (busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runVector(input vector_t v);
        int lat;
        int busyCnt;
        logic [N:0] held;
        applyStimulus(v.a, v.b, lat, busyCnt);
        checkOutput({v.name, " latency"}, (N+1)'(lat), (N+1)'(LAT));
        checkOutput({v.name, " busy cycles"}, (N+1)'(busyCnt), (N+1)'(LAT));
        checkOutput({v.name, " RES"}, RES, v.expRes);
`ifdef SUBTRATOR_OVERFLOW_EN
        checkOutput({v.name, " ovf"}, (N+1)'(ovf), (N+1)'(v.expOvf));
`endif
        held = RES;
        @(negedge clk);
        checkOutput({v.name, " done pulse width"}, (N+1)'(done), '0);
        checkOutput({v.name, " RES held"}, RES, held);
    endtask

    vector_t vecs[$];

    initial begin
        int lat;
        int busyCnt;
        int sawDone;

        vecs.push_back('{64'd10, 64'd3, {1'b0, 64'd7}, 1'b0, "simple"});
        vecs.push_back('{64'd0, 64'd1, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, "full borrow"});
        vecs.push_back('{64'h100, 64'h1, {1'b0, 64'hFF}, 1'b0, "inter-chunk borrow"});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'd0, 1'b0, "equal"});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'd1, {1'b0, 64'h7FFF_FFFF_FFFF_FFFF}, 1'b1, "signed ovf"});
        vecs.push_back('{64'd5, 64'd3, {1'b0, 64'd2}, 1'b0, "no ovf"});
        vecs.push_back('{64'd1, 64'h8000_0000_0000_0000, {1'b1, 64'h8000_0000_0000_0001}, 1'b1, "neg ovf"});
        vecs.push_back('{64'h0123_4567_89AB_CDEF, 64'h0023_4567_89AB_CDF0, {1'b0, 64'h00FF_FFFF_FFFF_FFFF}, 1'b0, "mixed"});

        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset RES", RES, '0);
        checkOutput("reset busy", (N+1)'(busy), '0);
        checkOutput("reset done", (N+1)'(done), '0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) runVector(vecs[i]);

        // A second start while busy must not disturb operands or timing.
        A = 64'd5; B = 64'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (2) begin @(negedge clk); lat++; end
        A = 64'd9; B = 64'd9; start = 1'b1;
        @(negedge clk); lat++;
        start = 1'b0;
        while (!done && lat < 20) begin @(negedge clk); lat++; end
        checkOutput("ignore latency", (N+1)'(lat), (N+1)'(LAT));
        checkOutput("ignore RES", RES, {1'b0, 64'd3});
        @(negedge clk);

        // Reset mid-operation: nothing partial may leak out and done never fires.
        A = 64'd5; B = 64'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid-op reset busy", (N+1)'(busy), '0);
        checkOutput("mid-op reset RES", RES, '0);
        sawDone = 0;
        repeat (12) begin
            if (done) sawDone = 1;
            @(negedge clk);
        end
        checkOutput("mid-op reset no done", (N+1)'(sawDone), '0);
        checkOutput("mid-op reset RES stays", RES, '0);

        // Start accepted in the very cycle after reset completes.
        A = 64'd5; B = 64'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(64'd5, 64'd2, lat, busyCnt);
        checkOutput("post-reset latency", (N+1)'(lat), (N+1)'(LAT));
        checkOutput("post-reset RES", RES, {1'b0, 64'd3});

        // Start in the done cycle is accepted straight away.
        applyStimulus(64'd20, 64'd30, lat, busyCnt);
        checkOutput("back-to-back latency", (N+1)'(lat), (N+1)'(LAT));
        checkOutput("back-to-back RES", RES, {1'b1, 64'hFFFF_FFFF_FFFF_FFF6});

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
